y86_seq_ctrl: RTL and testbench
===============================

# y86_seq_ctrl

Stage sequencer for the sequential Y86-64 core. Steps one instruction at a time through fetch, decode, execute, memory, writeback and PC update, and emits one-hot stage enables to the datapath blocks. Owns the architectural PC register and the next-PC selection, and stalls the memory stage on a data-memory handshake. Tracks processor status (AOK/HLT/ADR/INS) and a retired-instruction counter.

## Interface
- RESET_PC, 64'h0: PC value loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- icode  in  4  instruction code from the fetch block; valid while f_en=1.
- instr_valid  in  1  fetch block decoded a legal instruction; sampled with icode.
- imem_error  in  1  fetch address out of range; sampled with icode.
- cnd  in  1  condition result from execute; sampled in PCUPD.
- valC, valM, valP  in  64 each  constant word, memory read value, fall-through PC; sampled in PCUPD.
- mem_ready  in  1  data memory access complete; meaningful only while m_en=1.
- dmem_error  in  1  data memory fault; qualified by m_en & mem_ready.
- pc  out  64  current instruction address.
- f_en, d_en, e_en, m_en, w_en, p_en  out  1 each  one-hot stage enables.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high in HALT state.
- instr_count  out  64  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRBACK, PCUPD, HALT. Enables are Moore outputs: f_en in FETCH, d_en in DECODE, e_en in EXECUTE, m_en in MEMORY, w_en in WRBACK, p_en in PCUPD; all zero in IDLE/HALT.
- icode is latched into an internal register at the end of FETCH; all later decisions use the latched copy.
- IDLE -> FETCH when start=1, else hold.
- FETCH end, priority order: imem_error=1 -> stat=ADR, HALT; instr_valid=0 -> stat=INS, HALT; icode=0 (halt) -> stat=HLT, HALT; otherwise DECODE.
- DECODE -> EXECUTE -> MEMORY unconditionally, one cycle each.
- MEMORY: for memory icodes (4,5,8,9,A,B), hold until mem_ready=1. On that cycle, dmem_error=1 -> stat=ADR, HALT; otherwise WRBACK. For all other icodes, one cycle, mem_ready/dmem_error ignored.
- WRBACK -> PCUPD, one cycle.
- PCUPD -> FETCH. At this edge pc loads next PC and instr_count increments by 1 (wraps 2^64-1 -> 0).
- Next PC: icode 7 (jXX): cnd ? valC : valP; 8 (call): valC; 9 (ret): valM; all others: valP.
- HALT is terminal; only rst_n leaves it. pc holds the address of the faulting/halt instruction. instr_count excludes the halting instruction.
- start is ignored outside IDLE.

## Timing
- Reset (async assert, any state, including mid-MEMORY wait): state=IDLE, pc=RESET_PC, stat=AOK (1), instr_count=0, all enables 0, halted=0. Deassertion is synchronized externally; the first state change is on the first rising edge with rst_n=1.
- First f_en: one cycle after start is sampled high in IDLE.
- Non-memory instruction: 6 cycles FETCH..PCUPD. Memory instruction: 6 + N cycles, where N = cycles with m_en=1 and mem_ready=0.
- mem_ready already high on the first MEMORY cycle: no stall.
- stat and halted change on the same edge that enters HALT; halted=1 exactly when state=HALT.
- No instruction is retired in the cycle an error is flagged; pc is not updated.

## Test plan
- Reset/start: hold rst_n=0 with RESET_PC=64'h100 -> pc=0x100, stat=1, enables 0. Release, start=1 -> f_en high one cycle later, then d_en,e_en,m_en,w_en,p_en, each one cycle.
- Straight-line: icode=6, valP=0x102 -> pc=0x102 after 6 cycles, instr_count=1. Then icode=7, cnd=0, valC=0x200, valP=0x10B -> pc=0x10B. Then icode=7, cnd=1 -> pc=0x200.
- call/ret with stall: icode=8, valC=0x400, mem_ready low for 3 MEMORY cycles -> m_en high 4 cycles, pc=0x400 after 9 cycles. Then icode=9, valM=0x10B -> pc=0x10B.
- Faults: imem_error=1 with instr_valid=0 at FETCH -> stat=3 (ADR wins), halted=1, pc unchanged. Separate run: instr_valid=0 -> stat=4. Separate run: icode=5, dmem_error=1 with mem_ready=1 -> stat=3, w_en never asserted.
- Halt: icode=0 at FETCH -> stat=2, halted=1. Toggling start has no effect. instr_count stays at the prior value.
- Async reset mid-stall: assert rst_n=0 during a MEMORY wait -> immediate IDLE, pc=RESET_PC, instr_count=0, m_en=0 without waiting for a clock edge.

Source files
------------

// File: rtl/y86_seq_ctrl.sv
// Stage sequencer for the sequential Y86-64 core: walks one instruction through
// FETCH..PCUPD, owns the architectural PC, retire counter and processor status.
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic [63:0] valP,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic [63:0] pc,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        p_en,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WRBACK  = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    state_t      state_q, state_d;
    logic [2:0]  stat_q, stat_d;
    logic [3:0]  icode_q, icode_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] count_q, count_d;

    logic        is_mem_instr;
    logic [63:0] next_pc;

    // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
    always_comb begin
        is_mem_instr = 1'b0;
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_instr = 1'b1;
            default:                            is_mem_instr = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = valP;
        case (icode_q)
            IC_JXX:  next_pc = cnd ? valC : valP;
            IC_CALL: next_pc = valC;
            IC_RET:  next_pc = valM;
            default: next_pc = valP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stat_q  <= STAT_AOK;
            icode_q <= 4'h0;
            pc_q    <= RESET_PC;
            count_q <= 64'd0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        icode_d = icode_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                icode_d = icode;
                // fetch faults outrank an illegal encoding, which outranks halt
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = S_HALT;
                end else if (icode == IC_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = S_HALT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_MEMORY;
            S_MEMORY: begin
                if (!is_mem_instr) begin
                    state_d = S_WRBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WRBACK;
                    end
                end
            end
            S_WRBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                state_d = S_FETCH;
                pc_d    = next_pc;
                count_d = count_q + 64'd1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        f_en   = 1'b0;
        d_en   = 1'b0;
        e_en   = 1'b0;
        m_en   = 1'b0;
        w_en   = 1'b0;
        p_en   = 1'b0;
        halted = 1'b0;
        case (state_q)
            S_FETCH:   f_en   = 1'b1;
            S_DECODE:  d_en   = 1'b1;
            S_EXECUTE: e_en   = 1'b1;
            S_MEMORY:  m_en   = 1'b1;
            S_WRBACK:  w_en   = 1'b1;
            S_PCUPD:   p_en   = 1'b1;
            S_HALT:    halted = 1'b1;
            default:   halted = 1'b0;
        endcase
    end

    assign pc          = pc_q;
    assign stat        = stat_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Randomized scoreboard bench for y86_seq_ctrl: a stimulus process plays the
// fetch/execute/memory blocks, a monitor checks every fetch and halt event.
module tb_y86_seq_ctrl;

    localparam logic [63:0] RPC = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic        instr_valid = 1'b0;
    logic        imem_error = 1'b0;
    logic        cnd = 1'b0;
    logic [63:0] valC = 64'h0;
    logic [63:0] valM = 64'h0;
    logic [63:0] valP = 64'h0;
    logic        mem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic [63:0] pc;
    logic        f_en, d_en, e_en, m_en, w_en, p_en;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] instr_count;

    y86_seq_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
        .valC(valC), .valM(valM), .valP(valP), .mem_ready(mem_ready),
        .dmem_error(dmem_error), .pc(pc), .f_en(f_en), .d_en(d_en),
        .e_en(e_en), .m_en(m_en), .w_en(w_en), .p_en(p_en), .stat(stat),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] cnt;
        logic [2:0]  stat;
        logic        halted;
        int          len;
    } exp_t;

    typedef struct {
        logic [3:0]  ic;
        logic        iv;
        logic        ime;
        logic        c;
        logic        dme;
        logic [63:0] vc;
        logic [63:0] vm;
        logic [63:0] vp;
        int          stall;
    } ins_t;

    exp_t exp_q[$];
    ins_t prog_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic [63:0] m_pc = RPC;
    logic [63:0] m_cnt = 64'd0;
    logic [2:0]  m_stat = 3'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    function automatic logic is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Architectural reference: what the next observable event should look like.
    function automatic exp_t model_step(input ins_t in);
        exp_t e;
        logic [63:0] nxt;
        if (in.ime) begin
            m_stat = 3'd3; e = '{m_pc, m_cnt, 3'd3, 1'b1, 1};
        end else if (!in.iv) begin
            m_stat = 3'd4; e = '{m_pc, m_cnt, 3'd4, 1'b1, 1};
        end else if (in.ic == 4'h0) begin
            m_stat = 3'd2; e = '{m_pc, m_cnt, 3'd2, 1'b1, 1};
        end else if (is_mem(in.ic) && in.dme) begin
            m_stat = 3'd3; e = '{m_pc, m_cnt, 3'd3, 1'b1, 4 + in.stall};
        end else begin
            if (in.ic == 4'h7)      nxt = in.c ? in.vc : in.vp;
            else if (in.ic == 4'h8) nxt = in.vc;
            else if (in.ic == 4'h9) nxt = in.vm;
            else                    nxt = in.vp;
            m_pc  = nxt;
            m_cnt = m_cnt + 64'd1;
            e = '{m_pc, m_cnt, 3'd1, 1'b0, 6 + (is_mem(in.ic) ? in.stall : 0)};
        end
        return e;
    endfunction

    function automatic ins_t mk(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                                input logic [63:0] vm, input logic [63:0] vp, input int stall);
        ins_t r;
        r = '{ic, 1'b1, 1'b0, c, 1'b0, vc, vm, vp, stall};
        return r;
    endfunction

    function automatic ins_t rand_ins();
        return mk(4'($urandom_range(1, 11)), 1'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    endfunction

    function automatic ins_t end_ins(input int kind);
        ins_t r;
        logic [3:0] mem_ics [6];
        mem_ics = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        r = rand_ins();
        case (kind)
            0: r.ic = 4'h0;
            1: begin r.ime = 1'b1; r.iv = 1'($urandom); r.ic = 4'($urandom); end
            2: begin r.iv = 1'b0; r.ic = 4'($urandom); end
            default: begin r.ic = mem_ics[$urandom_range(0, 5)]; r.dme = 1'b1; end
        endcase
        return r;
    endfunction

    // Monitor: pops one expectation per fetch or halt event.
    initial begin
        logic prev_f, prev_h, first_obs;
        int last_cyc;
        exp_t e;
        prev_f = 1'b0; prev_h = 1'b0; first_obs = 1'b1; last_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_f = 1'b0; prev_h = 1'b0; first_obs = 1'b1;
            end else begin
                chk64("enables_onehot", 64'($countones({f_en, d_en, e_en, m_en, w_en, p_en, halted}) <= 1), 64'd1);
                if (prev_h)
                    chk64("halt_sticky", {57'd0, halted, f_en, d_en, e_en, m_en, w_en, p_en}, 64'h40);
                if ((f_en && !prev_f) || (halted && !prev_h)) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event: f_en=%b halted=%b pc=%h with no expectation", f_en, halted, pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk64("pc", pc, e.pc);
                        chk64("instr_count", instr_count, e.cnt);
                        chk64("stat", 64'(stat), 64'(e.stat));
                        chk64("halted", 64'(halted), 64'(e.halted));
                        chk64("cycles", 64'(cyc - (first_obs ? start_cyc : last_cyc)), 64'(e.len));
                    end
                    last_cyc = cyc;
                    first_obs = 1'b0;
                end
                prev_f = f_en;
                prev_h = halted;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        dmem_error = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk64("rst_pc", pc, RPC);
        chk64("rst_stat", 64'(stat), 64'd1);
        chk64("rst_count", instr_count, 64'd0);
        chk64("rst_enables", {57'd0, f_en, d_en, e_en, m_en, w_en, p_en, halted}, 64'd0);
        rst_n = 1'b1;
        m_pc = RPC; m_cnt = 64'd0; m_stat = 3'd1;
        repeat (2) @(negedge clk);
        chk64("idle_no_fetch", 64'(f_en), 64'd0);
    endtask

    task automatic start_prog();
        exp_q.push_back('{RPC, 64'd0, 3'd1, 1'b0, 1});
        start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic exec_instr(input ins_t in, output bit ok);
        int stall_left;
        bit done;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (f_en) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin timeout_fail("wait_fetch"); return; end
        icode = in.ic; instr_valid = in.iv; imem_error = in.ime;
        cnd = in.c; valC = in.vc; valM = in.vm; valP = in.vp;
        exp_q.push_back(model_step(in));
        stall_left = in.stall;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            // only the latched icode may steer the rest of the instruction
            icode = 4'($urandom); instr_valid = 1'($urandom); imem_error = 1'($urandom);
            if (halted || p_en) begin done = 1'b1; break; end
            if (m_en && is_mem(in.ic)) begin
                if (stall_left > 0) begin
                    mem_ready = 1'b0; dmem_error = 1'($urandom); stall_left--;
                end else begin
                    mem_ready = 1'b1; dmem_error = in.dme;
                end
            end else begin
                mem_ready = 1'($urandom); dmem_error = 1'($urandom);
            end
        end
        if (!done) begin timeout_fail("wait_retire"); ok = 1'b0; end
    endtask

    task automatic halt_tail();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'($urandom);
        end
        chk64("halt_pc", pc, m_pc);
        chk64("halt_count", instr_count, m_cnt);
        chk64("halt_stat", 64'(stat), 64'(m_stat));
        chk64("halt_level", 64'(halted), 64'd1);
        chk64("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_prog();
        bit ok;
        start_prog();
        foreach (prog_q[i]) begin
            exec_instr(prog_q[i], ok);
            if (!ok) break;
        end
        halt_tail();
    endtask

    initial begin
        bit ok;
        int mcount;
        #1;
        do_reset();

        prog_q.delete();
        prog_q.push_back(mk(4'h6, 1'b0, 64'h0,   64'h0,   64'h102, 0));
        prog_q.push_back(mk(4'h7, 1'b0, 64'h200, 64'h0,   64'h10B, 0));
        prog_q.push_back(mk(4'h7, 1'b1, 64'h200, 64'h0,   64'h114, 0));
        prog_q.push_back(mk(4'h8, 1'b0, 64'h400, 64'h0,   64'h209, 3));
        prog_q.push_back(mk(4'h9, 1'b0, 64'h0,   64'h10B, 64'h401, 0));
        prog_q.push_back(end_ins(0));
        run_prog();

        for (int r = 0; r < 4; r++) begin
            do_reset();
            prog_q.delete();
            for (int i = 0; i < 25; i++) prog_q.push_back(rand_ins());
            prog_q.push_back(end_ins(r));
            run_prog();
        end

        do_reset();
        start_prog();
        for (int i = 0; i < 2; i++) begin
            exec_instr(mk(4'h6, 1'b0, 64'h0, 64'h0, {$urandom, $urandom}, 0), ok);
        end
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (f_en) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) timeout_fail("stall_fetch");
        icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0;
        mcount = 0;
        for (int k = 0; k < 50 && mcount < 3; k++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (m_en) mcount++;
        end
        chk64("stall_seen", 64'(mcount), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk64("async_m_en", 64'(m_en), 64'd0);
        chk64("async_pc", pc, RPC);
        chk64("async_count", instr_count, 64'd0);
        chk64("async_stat", 64'(stat), 64'd1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
